// File: rtl/debug_pkg.sv
// Shared debug-subsystem types: DM register map, JTAG TAP states, DTM IR codes
// and DMI op/status encodings.
package debug_pkg;

    typedef enum logic [6:0] {
        DM_DATA0      = 7'h04,
        DM_DATA1      = 7'h05,
        DM_DMCONTROL  = 7'h10,
        DM_DMSTATUS   = 7'h11,
        DM_HARTINFO   = 7'h12,
        DM_ABSTRACTCS = 7'h16,
        DM_COMMAND    = 7'h17,
        DM_SBCS       = 7'h38
    } dm_addresses_e;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [4:0] {
        IR_IDCODE = 5'h01,
        IR_DTMCS  = 5'h10,
        IR_DMI    = 5'h11,
        IR_BYPASS = 5'h1f
    } dtm_ir_e;

    typedef enum logic [1:0] {
        REQ_IDLE, REQ_REQ, REQ_WAIT
    } req_state_e;

    localparam logic [1:0] DMI_NOP = 2'd0;
    localparam logic [1:0] DMI_RD  = 2'd1;
    localparam logic [1:0] DMI_WR  = 2'd2;

    localparam logic [1:0] DMISTAT_OK   = 2'd0;
    localparam logic [1:0] DMISTAT_BUSY = 2'd3;

    // IEEE 1149.1 TAP state transition on a TCK rising edge.
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PAU_DR;
            PAU_DR:  return tms ? EX2_DR : PAU_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PAU_IR;
            PAU_IR:  return tms ? EX2_IR : PAU_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            UPD_IR:  return tms ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

endpackage

// File: rtl/dbg_jtag_tap.sv
// Oversampled JTAG TAP: pin synchronizers, tck edge strobes, TAP state machine
// and the instruction register.
module dbg_jtag_tap
    import debug_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tck_i,
    input  logic       tms_i,
    input  logic       tdi_i,
    input  logic       trst_ni,
    output logic       tck_fall,
    output logic       tdi,
    output logic       cap_dr,
    output logic       sh_dr,
    output logic       upd_dr,
    output logic       shift_ir,
    output logic       shift_dr,
    output logic       ir_lsb,
    output logic [4:0] ir
);

    // tck carries one extra flop so both edges come from synchronized samples.
    logic [SYNC_STAGES:0]   tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync, tdi_sync, trst_sync;
    logic                   tck_rise, tms, trst;
    tap_state_e             state;
    logic [4:0]             ir_sr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-1:0], tck_i};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms_i};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi_i};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_ni};
        end
    end

    assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_sync[SYNC_STAGES];
    assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_sync[SYNC_STAGES];
    assign tms      = tms_sync[SYNC_STAGES-1];
    assign tdi      = tdi_sync[SYNC_STAGES-1];
    assign trst     = ~trst_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= TLR;
            ir    <= IR_IDCODE;
            ir_sr <= '0;
        end else if (trst) begin
            state <= TLR;
            ir    <= IR_IDCODE;
        end else begin
            if (tck_rise) begin
                state <= tap_next(state, tms);
                case (state)
                    CAP_IR:  ir_sr <= 5'b00001;
                    SH_IR:   ir_sr <= {tdi, ir_sr[4:1]};
                    UPD_IR:  ir    <= ir_sr;
                    default: ;
                endcase
            end
            if (state == TLR)
                ir <= IR_IDCODE;
        end
    end

    assign cap_dr   = tck_rise && (state == CAP_DR);
    assign sh_dr    = tck_rise && (state == SH_DR);
    assign upd_dr   = tck_rise && (state == UPD_DR);
    assign shift_ir = (state == SH_IR);
    assign shift_dr = (state == SH_DR);
    assign ir_lsb   = ir_sr[0];

endmodule

// File: rtl/dbg_dtm_jtag.sv
// RISC-V 0.13 JTAG DTM: IDCODE/DTMCS/DMI/BYPASS data registers and the DMI
// request sequencer that turns DMI scans into single-cycle read/write pulses.
module dbg_dtm_jtag
    import debug_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h1000_0A6D,
    parameter int          ABITS       = 7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tck_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    input  logic             trst_ni,
    output logic             tdo_o,
    output logic             tdo_oe_o,
    output logic             dmi_wr_o,
    output logic             dmi_rd_o,
    output logic [ABITS-1:0] dmi_ad_o,
    output logic [31:0]      dmi_do_o,
    input  logic [31:0]      dmi_di_i
);

    localparam int DMI_W = ABITS + 34;

    logic             tck_fall, tdi, cap_dr, sh_dr, upd_dr, shift_ir, shift_dr, ir_lsb;
    logic [4:0]       ir;
    logic [DMI_W-1:0] dr_sr, dr_cap, dr_shift;
    logic [31:0]      rdata, dtmcs_cap;
    logic [1:0]       dmistat, cap_stat, dmi_op;
    req_state_e       req_q;
    logic             pending;

    dbg_jtag_tap #(.SYNC_STAGES(SYNC_STAGES)) u_tap (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tck_i    (tck_i),
        .tms_i    (tms_i),
        .tdi_i    (tdi_i),
        .trst_ni  (trst_ni),
        .tck_fall (tck_fall),
        .tdi      (tdi),
        .cap_dr   (cap_dr),
        .sh_dr    (sh_dr),
        .upd_dr   (upd_dr),
        .shift_ir (shift_ir),
        .shift_dr (shift_dr),
        .ir_lsb   (ir_lsb),
        .ir       (ir)
    );

    assign pending   = (req_q != REQ_IDLE);
    // A scan that captures while a request is in flight reports busy without making it sticky.
    assign cap_stat  = pending ? DMISTAT_BUSY : dmistat;
    assign dtmcs_cap = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
    assign dmi_op    = dr_sr[1:0];

    always_comb begin
        dr_cap   = '0;
        dr_shift = dr_sr >> 1;
        case (ir)
            IR_IDCODE: begin
                dr_cap       = {{(DMI_W-32){1'b0}}, IDCODE | 32'd1};
                dr_shift[31] = tdi;
            end
            IR_DTMCS: begin
                dr_cap       = {{(DMI_W-32){1'b0}}, dtmcs_cap};
                dr_shift[31] = tdi;
            end
            IR_DMI: begin
                dr_cap             = {dmi_ad_o, rdata, cap_stat};
                dr_shift[DMI_W-1]  = tdi;
            end
            default: dr_shift = {{(DMI_W-1){1'b0}}, tdi};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_oe_o <= shift_ir | shift_dr;
            if (tck_fall)
                tdo_o <= shift_ir ? ir_lsb : dr_sr[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dr_sr    <= '0;
            rdata    <= '0;
            dmistat  <= DMISTAT_OK;
            req_q    <= REQ_IDLE;
            dmi_wr_o <= 1'b0;
            dmi_rd_o <= 1'b0;
            dmi_ad_o <= '0;
            dmi_do_o <= '0;
        end else begin
            dmi_wr_o <= 1'b0;
            dmi_rd_o <= 1'b0;

            case (req_q)
                REQ_REQ:  req_q <= dmi_rd_o ? REQ_WAIT : REQ_IDLE;
                REQ_WAIT: begin
                    rdata <= dmi_di_i;
                    req_q <= REQ_IDLE;
                end
                default: ;
            endcase

            if (cap_dr)
                dr_sr <= dr_cap;
            else if (sh_dr)
                dr_sr <= dr_shift;

            if (upd_dr && ir == IR_DTMCS) begin
                if (dr_sr[17]) begin
                    dmistat <= DMISTAT_OK;
                    req_q   <= REQ_IDLE;
                end else if (dr_sr[16]) begin
                    dmistat <= DMISTAT_OK;
                end
            end else if (upd_dr && ir == IR_DMI && dmistat == DMISTAT_OK) begin
                if (pending) begin
                    dmistat <= DMISTAT_BUSY;
                end else begin
                    case (dmi_op)
                        DMI_RD: begin
                            dmi_rd_o <= 1'b1;
                            dmi_ad_o <= dr_sr[DMI_W-1:34];
                            req_q    <= REQ_REQ;
                        end
                        DMI_WR: begin
                            dmi_wr_o <= 1'b1;
                            dmi_ad_o <= dr_sr[DMI_W-1:34];
                            dmi_do_o <= dr_sr[33:2];
                            req_q    <= REQ_REQ;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/dbg_dtm_jtag.md
Name: dbg_dtm_jtag

Overview:
- JTAG Debug Transport Module: the stage directly upstream of the debug module. It converts an external JTAG port into single-cycle DMI read/write pulses on the dm DMI interface.
- JTAG pins are oversampled in the system clock domain, so there is one clock and no CDC FIFO.
- Implements the RISC-V debug 0.13 DTM: TAP controller, 5-bit IR, IDCODE, DTMCS, DMI and BYPASS registers, and DMI busy/error status.

Parameters:
- IDCODE, 32'h1000_0A6D, value returned by the IDCODE register; bit 0 forced to 1.
- ABITS, 7, DMI address width; equals the width of dm_addresses_e.
- SYNC_STAGES, 2, synchronizer depth on tck_i, tms_i, tdi_i, trst_ni.

Ports:
- clk_i  in  1  system clock; must be at least 4x the tck frequency.
- rst_ni  in  1  asynchronous active-low reset.
- tck_i  in  1  JTAG clock, asynchronous, oversampled.
- tms_i  in  1  JTAG mode select.
- tdi_i  in  1  JTAG data in.
- trst_ni  in  1  JTAG test reset, active-low, synchronized; acts as TAP reset only.
- tdo_o  out  1  JTAG data out.
- tdo_oe_o  out  1  tdo drive enable; high only in SHIFT_IR/SHIFT_DR.
- dmi_wr_o  out  1  one-cycle DMI write pulse.
- dmi_rd_o  out  1  one-cycle DMI read pulse.
- dmi_ad_o  out  ABITS  DMI address, type dm_addresses_e.
- dmi_do_o  out  32  DMI write data.
- dmi_di_i  in  32  DMI read data; valid the cycle after dmi_rd_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - TAP state TEST_LOGIC_RESET; IR = IDCODE (5'h01).
  - All shift registers 0; sticky status 0.
  - All outputs 0 except dmi_ad_o = 0.
- Sampling:
  - Inputs pass through SYNC_STAGES flops.
  - tck_rise / tck_fall are single-cycle strobes from the last two synchronized tck samples.
  - Other input edges are ignored.
- TAP FSM:
  - Standard 16 states (IEEE 1149.1): TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR and the IR equivalents.
  - Advances only on tck_rise, using the synchronized tms.
  - Synchronized trst_ni low forces TLR immediately.
  - In TLR, IR = IDCODE.
- Register actions, all on tck_rise, per current state:
  - CAP_IR: IR shift register <= 5'b00001.
  - SH_IR: shift right with tdi in at MSB.
  - UPD_IR: IR <= shift register.
  - CAP_DR: load the selected register's capture value.
  - SH_DR: shift right, tdi in at MSB, length set by IR.
  - UPD_DR: commit.
- IR decode:
  - 5'h01 IDCODE (32 bits).
  - 5'h10 DTMCS (32 bits).
  - 5'h11 DMI (ABITS+34 bits).
  - Any other code is BYPASS (1 bit, captures 0).
- tdo:
  - tdo_o <= LSB of the active shift register on tck_fall; holds otherwise.
  - tdo_oe_o follows the SH_IR/SH_DR state.
- DTMCS capture value: {14'd0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits=ABITS[5:0], version=4'd1}.
- DTMCS update:
  - Bit 16 (dmireset) clears sticky dmistat.
  - Bit 17 (dmihardreset) clears sticky dmistat and the pending flag.
  - All other bits are ignored.
- DMI register: {addr[ABITS-1:0], data[31:0], op[1:0]}.
  - Capture: {last_addr, rdata, dmistat}.
  - dmistat: 0 = ok, 3 = busy. Code 2 is never generated.
- DMI update, when leaving UPD_DR with IR = DMI:
  - If dmistat != 0, the request is dropped.
  - Else if pending = 1, dmistat <= 3 (sticky) and the request is dropped.
  - Else per op:
    - op = 1: dmi_rd_o pulses for exactly one cycle, the cycle after the tck_rise in UPD_DR; dmi_ad_o = addr.
    - op = 2: dmi_wr_o pulses likewise; dmi_do_o = data.
    - op = 0 or 3: nop, no pulse.
  - dmi_ad_o and dmi_do_o hold their values until the next request.
- Request FSM: IDLE -> REQ (pulse cycle) -> WAIT (read only) -> IDLE.
  - Read path: in WAIT, rdata <= dmi_di_i.
  - pending = 1 in REQ and WAIT; write returns to IDLE after REQ.
  - dmi_wr_o and dmi_rd_o are never high together.
- Boundaries:
  - A tck_rise during REQ/WAIT is still processed by the TAP.
  - A CAP_DR occurring while pending returns dmistat = 3 and previous rdata.
  - Reset mid-request drops the pulse with no partial commit.
  - trst_ni resets the TAP/IR only and preserves dmistat.

Decomposition:
- In debug_pkg:
  - dm_addresses_e (existing).
  - New tap_state_e and dtm_ir_e enums.
  - DMI op codes DMI_NOP/DMI_RD/DMI_WR.
  - dmistat codes.
- One sub-module, dbg_jtag_tap: synchronizers, edge detect, TAP FSM, IR. Outputs state strobes and the ir value.
- The DTM top holds the data registers and the request FSM.

Test Plan:
- After reset, shift DR 32 bits with no IR scan -> tdo sequence LSB-first equals 0x1000_0A6D.
- IR = 5'h10, capture DTMCS -> reads 0x0000_1071 (idle 1, abits 7, version 1).
- IR = 5'h11, shift {addr=7'h04, data=0xDEAD_BEEF, op=2} -> one-cycle dmi_wr_o with dmi_ad_o = 7'h04 and dmi_do_o = 0xDEAD_BEEF; dmi_rd_o stays 0.
- Shift {addr=7'h04, op=1}; dm returns 0xDEAD_BEEF next cycle; following capture/shift -> tdo yields op = 0, data = 0xDEAD_BEEF, addr = 7'h04.
- Force pending (stub holds WAIT) and issue a second op = 2 -> no dmi_wr_o, capture op = 3. Then DTMCS write bit 16 -> next capture op = 0 and requests accepted again.
- Hold tms = 1 for 5 tck from any state -> TLR and IR = IDCODE; assert rst_ni low mid-REQ -> dmi_rd_o/dmi_wr_o = 0 immediately.
